conv_kernel_scheduler: RTL

Sequences the HLS convolution kernel through its AXI-lite `control` slave. Job descriptors (source address, destination address, length) are queued in a small FIFO. For each job the scheduler writes the kernel argument registers, sets ap_start, and waits for ap_done by interrupt or by polling. It then acknowledges the kernel and returns a completion record. It sits between the SoC-side job source (core MMIO or DMA front-end) and the kernel's control port, and owns that port exclusively.

---
 rtl/conv_sched_pkg.sv | 36 +++
 rtl/conv_job_fifo.sv | 52 +++++
 rtl/conv_kernel_scheduler.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and register map for the convolution kernel scheduler.
// Interrupt-driven completion is built in when CONV_SCHED_IRQ_EN is defined.
package conv_sched_pkg;

  // Kernel control register offsets, relative to CTRL_BASE
  localparam logic [31:0] OfsApCtrl = 32'h00;
  localparam logic [31:0] OfsGie    = 32'h04;
  localparam logic [31:0] OfsIer    = 32'h08;
  localparam logic [31:0] OfsIsr    = 32'h0C;
  localparam logic [31:0] OfsSrc    = 32'h10;
  localparam logic [31:0] OfsDst    = 32'h18;
  localparam logic [31:0] OfsLen    = 32'h20;

  localparam logic [1:0]  RespOkay  = 2'b00;
  localparam logic [31:0] WordOne   = 32'h1;

  typedef enum logic [3:0] {
    StIdle,
    StWrSrc,
    StWrDst,
    StWrLen,
    StWrGie,
    StWrIer,
    StStart,
    StWait,
    StAck,
    StDone
  } conv_sched_state_e;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
  } conv_job_t;

endpackage

// File: rtl/conv_job_fifo.sv
// Synchronous job-descriptor FIFO; pushes while full and pops while empty are dropped.
// Built identically with or without CONV_SCHED_IRQ_EN.
module conv_job_fifo
  import conv_sched_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  conv_job_t data_i,
  input  logic      pop_i,
  output conv_job_t data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  // Pointers carry one wrap bit so full and empty are distinguishable
  logic [PtrW:0] wptr_q, wptr_d;
  logic [PtrW:0] rptr_q, rptr_d;
  conv_job_t     mem_q [Depth];
  logic          wr_en, rd_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);

  assign wr_en  = push_i && !full_o;
  assign rd_en  = pop_i && !empty_o;
  assign wptr_d = wptr_q + {{PtrW{1'b0}}, wr_en};
  assign rptr_d = rptr_q + {{PtrW{1'b0}}, rd_en};
  assign data_o = mem_q[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wptr_q[PtrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/conv_kernel_scheduler.sv
// Queues convolution jobs and drives the HLS kernel's AXI-lite control port for each one.
// Define CONV_SCHED_IRQ_EN to wait on the kernel interrupt instead of polling AP_CTRL.
module conv_kernel_scheduler
  import conv_sched_pkg::*;
#(
  parameter logic [31:0] CTRL_BASE  = 32'h0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned POLL_GAP   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        job_valid_i,
  output logic        job_ready_o,
  input  logic [31:0] job_src_i,
  input  logic [31:0] job_dst_i,
  input  logic [31:0] job_len_i,
  output logic        done_valid_o,
  input  logic        done_ready_i,
  output logic        done_err_o,
  output logic        busy_o,
  input  logic        kernel_irq_i,
  output logic        m_axilite_awvalid_o,
  input  logic        m_axilite_awready_i,
  output logic [31:0] m_axilite_awaddr_o,
  output logic [2:0]  m_axilite_awprot_o,
  output logic        m_axilite_wvalid_o,
  input  logic        m_axilite_wready_i,
  output logic [31:0] m_axilite_wdata_o,
  output logic [3:0]  m_axilite_wstrb_o,
  input  logic        m_axilite_bvalid_i,
  output logic        m_axilite_bready_o,
  input  logic [1:0]  m_axilite_bresp_i,
  output logic        m_axilite_arvalid_o,
  input  logic        m_axilite_arready_i,
  output logic [31:0] m_axilite_araddr_o,
  output logic [2:0]  m_axilite_arprot_o,
  input  logic        m_axilite_rvalid_i,
  output logic        m_axilite_rready_o,
  input  logic [31:0] m_axilite_rdata_i,
  input  logic [1:0]  m_axilite_rresp_i
);

  localparam int unsigned GapW = $clog2(POLL_GAP + 1);

  conv_sched_state_e state_q, state_d;
  conv_job_t         job_q, job_d;
  logic              err_q, err_d;
  logic              done_valid_q, done_valid_d;
  logic              awvalid_q, awvalid_d;
  logic [31:0]       awaddr_q, awaddr_d;
  logic              wvalid_q, wvalid_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic [31:0]       araddr_q, araddr_d;
  logic              rready_q, rready_d;
  logic [GapW-1:0]   gap_q, gap_d;

  conv_job_t fifo_wdata, fifo_rdata;
  logic      fifo_pop, fifo_full, fifo_empty;

  assign fifo_wdata = '{src: job_src_i, dst: job_dst_i, len: job_len_i};

  conv_job_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (job_valid_i),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Successor of each write state once its B response is OKAY
  function automatic conv_sched_state_e next_wr_state(input conv_sched_state_e s);
    case (s)
      StWrSrc: return StWrDst;
      StWrDst: return StWrLen;
`ifdef CONV_SCHED_IRQ_EN
      StWrLen: return StWrGie;
`else
      StWrLen: return StStart;
`endif
      StWrGie: return StWrIer;
      StWrIer: return StStart;
      StStart: return StWait;
      default: return StDone;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    job_d        = job_q;
    err_d        = err_q;
    done_valid_d = done_valid_q;
    awvalid_d    = awvalid_q;
    awaddr_d     = awaddr_q;
    wvalid_d     = wvalid_q;
    wdata_d      = wdata_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    araddr_d     = araddr_q;
    rready_d     = rready_q;
    gap_d        = gap_q;
    fifo_pop     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !done_valid_q) begin
          fifo_pop = 1'b1;
          job_d    = fifo_rdata;
          state_d  = StWrSrc;
        end
      end
      StWrSrc, StWrDst, StWrLen, StWrGie, StWrIer, StStart, StAck: begin
        if (awvalid_q && m_axilite_awready_i) awvalid_d = 1'b0;
        if (wvalid_q && m_axilite_wready_i) wvalid_d = 1'b0;
        // BREADY waits until AW and W have both been accepted
        if (!bready_q) begin
          if ((!awvalid_q || m_axilite_awready_i) && (!wvalid_q || m_axilite_wready_i)) begin
            bready_d = 1'b1;
          end
        end else if (m_axilite_bvalid_i) begin
          bready_d = 1'b0;
          if (m_axilite_bresp_i != RespOkay) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = next_wr_state(state_q);
          end
        end
      end
      StWait: begin
`ifdef CONV_SCHED_IRQ_EN
        if (kernel_irq_i) state_d = StAck;
`else
        if (rready_q) begin
          if (m_axilite_rvalid_i) begin
            rready_d = 1'b0;
            if (m_axilite_rresp_i != RespOkay) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else if (m_axilite_rdata_i[1]) begin
              state_d = StDone;
            end else begin
              gap_d = GapW'(POLL_GAP);
            end
          end
        end else if (arvalid_q) begin
          if (m_axilite_arready_i) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
          end
        end else if (gap_q != '0) begin
          gap_d = gap_q - GapW'(1);
        end else begin
          arvalid_d = 1'b1;
          araddr_d  = CTRL_BASE + OfsApCtrl;
        end
`endif
      end
      StDone: begin
        if (done_ready_i) begin
          done_valid_d = 1'b0;
          err_d        = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Launch the transaction owned by the state being entered
    if (state_d != state_q) begin
      case (state_d)
        StWrSrc: begin awaddr_d = CTRL_BASE + OfsSrc;    wdata_d = job_d.src; end
        StWrDst: begin awaddr_d = CTRL_BASE + OfsDst;    wdata_d = job_q.dst; end
        StWrLen: begin awaddr_d = CTRL_BASE + OfsLen;    wdata_d = job_q.len; end
        StWrGie: begin awaddr_d = CTRL_BASE + OfsGie;    wdata_d = WordOne;   end
        StWrIer: begin awaddr_d = CTRL_BASE + OfsIer;    wdata_d = WordOne;   end
        StStart: begin awaddr_d = CTRL_BASE + OfsApCtrl; wdata_d = WordOne;   end
        StAck:   begin awaddr_d = CTRL_BASE + OfsIsr;    wdata_d = WordOne;   end
        StWait:  gap_d = GapW'(POLL_GAP);
        StDone:  done_valid_d = 1'b1;
        default: ;
      endcase
      if (state_d inside {StWrSrc, StWrDst, StWrLen, StWrGie, StWrIer, StStart, StAck}) begin
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      job_q        <= '0;
      err_q        <= 1'b0;
      done_valid_q <= 1'b0;
      awvalid_q    <= 1'b0;
      awaddr_q     <= '0;
      wvalid_q     <= 1'b0;
      wdata_q      <= '0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      rready_q     <= 1'b0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      job_q        <= job_d;
      err_q        <= err_d;
      done_valid_q <= done_valid_d;
      awvalid_q    <= awvalid_d;
      awaddr_q     <= awaddr_d;
      wvalid_q     <= wvalid_d;
      wdata_q      <= wdata_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      araddr_q     <= araddr_d;
      rready_q     <= rready_d;
      gap_q        <= gap_d;
    end
  end

`ifdef CONV_SCHED_IRQ_EN
  logic unused_rd_chan;
  assign unused_rd_chan = ^{m_axilite_arready_i, m_axilite_rvalid_i, m_axilite_rdata_i,
                            m_axilite_rresp_i};
`else
  logic unused_irq_bits;
  assign unused_irq_bits = ^{kernel_irq_i, m_axilite_rdata_i[31:2], m_axilite_rdata_i[0]};
`endif

  assign job_ready_o         = !fifo_full;
  assign done_valid_o        = done_valid_q;
  assign done_err_o          = err_q;
  assign busy_o              = (state_q != StIdle) || !fifo_empty;
  assign m_axilite_awvalid_o = awvalid_q;
  assign m_axilite_awaddr_o  = awaddr_q;
  assign m_axilite_awprot_o  = 3'b000;
  assign m_axilite_wvalid_o  = wvalid_q;
  assign m_axilite_wdata_o   = wdata_q;
  assign m_axilite_wstrb_o   = 4'hF;
  assign m_axilite_bready_o  = bready_q;
  assign m_axilite_arvalid_o = arvalid_q;
  assign m_axilite_araddr_o  = araddr_q;
  assign m_axilite_arprot_o  = 3'b000;
  assign m_axilite_rready_o  = rready_q;

endmodule
